// File: rtl/multi_button_counter.sv
// multi_button_counter: three debounced buttons (up/down/clear) driving a wrap-or-saturate counter.
// Defining MULTI_BUTTON_COUNTER_AUTOREPEAT_EN adds hold-to-repeat on the up and down buttons.

module multi_button_counter_checker #(
    parameter int WIDTH = 4
) (
    input logic             clk,
    input logic             rst,
    input logic [WIDTH-1:0] count,
    input logic             at_max,
    input logic             at_min,
    input logic             changed
);
    a_at_max : assert property (@(posedge clk) disable iff (rst) at_max == (count == {WIDTH{1'b1}}));
    a_at_min : assert property (@(posedge clk) disable iff (rst) at_min == (count == {WIDTH{1'b0}}));
    a_changed: assert property (@(posedge clk) disable iff (rst) changed |-> (count != $past(count)));
endmodule

module multi_button_counter #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int WRAP            = 1,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 250
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             changed
);
    localparam int NUM_BTN   = 3;
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_CLEAR = 2;

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(32'd1);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(32'd1);

    logic [NUM_BTN-1:0] raw_s;
    logic [NUM_BTN-1:0] sync1_r;
    logic [NUM_BTN-1:0] sync2_r;
    logic [NUM_BTN-1:0] filt_r;
    logic [NUM_BTN-1:0] filt_d_r;
    logic [NUM_BTN-1:0] press_s;
    logic [NUM_BTN-1:0] event_s;
    logic [DB_W-1:0]    db_cnt_r [NUM_BTN];
    logic [WIDTH-1:0]   count_next_s;

    assign raw_s   = {btn_clear, btn_down, btn_up};
    assign press_s = filt_r & ~filt_d_r;

    // Two-flop synchronisers plus one cycle of filtered-level history for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r  <= '0;
            sync2_r  <= '0;
            filt_d_r <= '0;
        end else begin
            sync1_r  <= raw_s;
            sync2_r  <= sync1_r;
            filt_d_r <= filt_r;
        end
    end

    // Debounce filters: a level change is accepted only after it persists DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_r <= '0;
            for (int b = 0; b < NUM_BTN; b++) begin
                db_cnt_r[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BTN; b++) begin
                if (sync2_r[b] == filt_r[b]) begin
                    db_cnt_r[b] <= '0;
                end else if (db_cnt_r[b] == DB_LAST) begin
                    filt_r[b]   <= sync2_r[b];
                    db_cnt_r[b] <= '0;
                end else begin
                    db_cnt_r[b] <= db_cnt_r[b] + DB_ONE;
                end
            end
        end
    end

`ifdef MULTI_BUTTON_COUNTER_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [RPT_W-1:0] RPT_ONE     = RPT_W'(32'd1);

    logic [RPT_W-1:0] rpt_cnt_r [2];
    logic [1:0]       rpt_armed_r;
    logic [1:0]       rpt_fire_s;

    // Repeat fires after the initial delay, then once per period while the level stays high.
    always_comb begin
        rpt_fire_s = 2'b00;
        for (int b = 0; b < 2; b++) begin
            if (filt_r[b] && !press_s[b]) begin
                if (rpt_armed_r[b]) begin
                    rpt_fire_s[b] = (rpt_cnt_r[b] == PERIOD_LAST);
                end else begin
                    rpt_fire_s[b] = (rpt_cnt_r[b] == DELAY_LAST);
                end
            end else begin
                rpt_fire_s[b] = 1'b0;
            end
        end
    end

    // Repeat timers restart on every press and stop as soon as the filtered level falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_armed_r <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                rpt_cnt_r[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (!filt_r[b] || press_s[b]) begin
                    rpt_cnt_r[b]   <= '0;
                    rpt_armed_r[b] <= 1'b0;
                end else if (rpt_fire_s[b]) begin
                    rpt_cnt_r[b]   <= '0;
                    rpt_armed_r[b] <= 1'b1;
                end else begin
                    rpt_cnt_r[b] <= rpt_cnt_r[b] + RPT_ONE;
                end
            end
        end
    end

    assign event_s = {press_s[BTN_CLEAR], press_s[BTN_DOWN:BTN_UP] | rpt_fire_s};
`else
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_unused
    end

    assign event_s = press_s;
`endif

    // Next count: clear wins, simultaneous up and down cancel, limits wrap or saturate.
    always_comb begin
        count_next_s = count;
        if (event_s[BTN_CLEAR]) begin
            count_next_s = CNT_ZERO;
        end else if (event_s[BTN_UP] && !event_s[BTN_DOWN]) begin
            if (count == CNT_MAX) begin
                count_next_s = (WRAP != 0) ? CNT_ZERO : CNT_MAX;
            end else begin
                count_next_s = count + CNT_ONE;
            end
        end else if (event_s[BTN_DOWN] && !event_s[BTN_UP]) begin
            if (count == CNT_ZERO) begin
                count_next_s = (WRAP != 0) ? CNT_MAX : CNT_ZERO;
            end else begin
                count_next_s = count - CNT_ONE;
            end
        end else begin
            count_next_s = count;
        end
    end

    // Flags are derived from the next count so they change on the same edge as count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= CNT_ZERO;
            at_max  <= 1'b0;
            at_min  <= 1'b1;
            changed <= 1'b0;
        end else begin
            count   <= count_next_s;
            at_max  <= (count_next_s == CNT_MAX);
            at_min  <= (count_next_s == CNT_ZERO);
            changed <= (count_next_s != count);
        end
    end

    multi_button_counter_checker #(
        .WIDTH(WIDTH)
    ) u_checker (
        .clk    (clk),
        .rst    (rst),
        .count  (count),
        .at_max (at_max),
        .at_min (at_min),
        .changed(changed)
    );
endmodule

// File: tb/tb_multi_button_counter.sv
// Bench for multi_button_counter: a wrapping and a saturating instance share one set of
// button inputs and are compared every cycle against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_multi_button_counter;
    localparam int DB   = 4;
    localparam int RD   = 10;
    localparam int RP   = 5;
    localparam int MAXV = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_clear = 1'b0;
    logic [3:0] count_w, count_s;
    logic       at_max_w, at_min_w, changed_w;
    logic       at_max_s, at_min_s, changed_s;

    int checks = 0;
    int errors = 0;

    // Model state: synchroniser stages, filtered levels, disagreement run lengths, hold ages.
    bit m_s1[3], m_s2[3], m_filt[3], m_fprev[3];
    int m_run[3];
    int m_age[2];
    int m_count[2];
    bit m_changed[2];
    bit model_live = 1'b0;
    bit saw_chg_w = 1'b0, saw_chg_s = 1'b0;

    multi_button_counter #(.WIDTH(4), .DEBOUNCE_CYCLES(DB), .WRAP(1),
                           .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_dut_wrap (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_clear(btn_clear),
        .count(count_w), .at_max(at_max_w), .at_min(at_min_w), .changed(changed_w));

    multi_button_counter #(.WIDTH(4), .DEBOUNCE_CYCLES(DB), .WRAP(0),
                           .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_dut_sat (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_clear(btn_clear),
        .count(count_s), .at_max(at_max_s), .at_min(at_min_s), .changed(changed_s));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit raw[3];
        bit ev[3];
        int nc;
        int age;
        raw[0] = btn_up; raw[1] = btn_down; raw[2] = btn_clear;
        if (rst) begin
            for (int b = 0; b < 3; b++) begin
                m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_filt[b] = 1'b0; m_fprev[b] = 1'b0; m_run[b] = 0;
            end
            for (int k = 0; k < 2; k++) begin
                m_age[k] = 0; m_count[k] = 0; m_changed[k] = 1'b0;
            end
            model_live = 1'b1;
        end else begin
            for (int b = 0; b < 3; b++) ev[b] = m_filt[b] && !m_fprev[b];
`ifdef MULTI_BUTTON_COUNTER_AUTOREPEAT_EN
            for (int b = 0; b < 2; b++) begin
                if (m_filt[b] && !ev[b]) begin
                    age = m_age[b] + 1;
                    m_age[b] = age;
                    if (age == RD || (age > RD && (age - RD) % RP == 0)) ev[b] = 1'b1;
                end else begin
                    m_age[b] = 0;
                end
            end
`endif
            for (int k = 0; k < 2; k++) begin
                nc = m_count[k];
                if (ev[2]) nc = 0;
                else if (ev[0] && !ev[1]) nc = (nc == MAXV) ? ((k == 0) ? 0 : MAXV) : nc + 1;
                else if (ev[1] && !ev[0]) nc = (nc == 0) ? ((k == 0) ? MAXV : 0) : nc - 1;
                m_changed[k] = (nc != m_count[k]);
                m_count[k] = nc;
            end
            for (int b = 0; b < 3; b++) begin
                m_fprev[b] = m_filt[b];
                if (m_s2[b] != m_filt[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB) begin
                        m_filt[b] = m_s2[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = raw[b];
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison of both instances against the model.
    initial forever begin
        @(negedge clk);
        if (changed_w) saw_chg_w = 1'b1;
        if (changed_s) saw_chg_s = 1'b1;
        if (model_live) begin
            check("count_wrap",   int'(count_w),   m_count[0]);
            check("at_max_wrap",  int'(at_max_w),  (m_count[0] == MAXV) ? 1 : 0);
            check("at_min_wrap",  int'(at_min_w),  (m_count[0] == 0) ? 1 : 0);
            check("changed_wrap", int'(changed_w), int'(m_changed[0]));
            check("count_sat",    int'(count_s),   m_count[1]);
            check("at_max_sat",   int'(at_max_s),  (m_count[1] == MAXV) ? 1 : 0);
            check("at_min_sat",   int'(at_min_s),  (m_count[1] == 0) ? 1 : 0);
            check("changed_sat",  int'(changed_s), int'(m_changed[1]));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input bit up, input bit dn, input bit clr);
        btn_up = up; btn_down = dn; btn_clear = clr;
    endtask

    task automatic press(input bit up, input bit dn, input bit clr);
        set_btn(up, dn, clr);
        cycles(DB + 2);
        set_btn(1'b0, 1'b0, 1'b0);
        cycles(DB + 4);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(2);
    endtask

    initial begin
        int hold;
        cycles(3);
        check("rst_count", int'(count_w), 0);
        check("rst_at_min", int'(at_min_w), 1);
        check("rst_at_max", int'(at_max_w), 0);
        check("rst_changed", int'(changed_w), 0);
        rst = 1'b0;
        cycles(2);

        // Latency: first sampling edge is edge 1, update lands on edge DB+3.
        btn_up = 1'b1;
        cycles(DB + 2);
        check("lat_before", int'(count_w), 0);
        cycles(1);
        check("lat_count", int'(count_w), 1);
        check("lat_changed", int'(changed_w), 1);
        check("lat_at_min", int'(at_min_w), 0);
        cycles(1);
        check("lat_pulse_end", int'(changed_w), 0);
        cycles(12);
        btn_up = 1'b0;
        cycles(10);
`ifdef MULTI_BUTTON_COUNTER_AUTOREPEAT_EN
        check("hold20_count", int'(count_w), 3);
`else
        check("hold20_count", int'(count_w), 1);
`endif

        // Short glitches never pass the filter.
        do_reset();
        saw_chg_w = 1'b0;
        for (int i = 0; i < 5; i++) begin
            btn_up = 1'b1; cycles(3);
            btn_up = 1'b0; cycles(5);
        end
        cycles(8);
        check("glitch_count", int'(count_w), 0);
        check("glitch_changed", int'(saw_chg_w), 0);

        // Sixteen presses: wrap versus saturate.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) saw_chg_s = 1'b0;
            press(1'b1, 1'b0, 1'b0);
            if (i == 14) begin
                check("p15_count_wrap", int'(count_w), 15);
                check("p15_at_max_wrap", int'(at_max_w), 1);
                check("p15_count_sat", int'(count_s), 15);
            end
        end
        check("p16_count_wrap", int'(count_w), 0);
        check("p16_at_min_wrap", int'(at_min_w), 1);
        check("p16_count_sat", int'(count_s), 15);
        check("p16_changed_sat", int'(saw_chg_s), 0);
        press(1'b0, 1'b1, 1'b0);
        check("down_wrap_from0", int'(count_w), 15);

        // Up+down cancel, clear beats up.
        do_reset();
        for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        check("cancel_count", int'(count_w), 5);
        press(1'b1, 1'b0, 1'b1);
        check("clear_up_count", int'(count_w), 0);
        saw_chg_w = 1'b0;
        press(1'b0, 1'b0, 1'b1);
        check("clear_at0_changed", int'(saw_chg_w), 0);

        // Reset in the middle of a down debounce.
        do_reset();
        for (int i = 0; i < 9; i++) press(1'b1, 1'b0, 1'b0);
        check("pre_rst_count", int'(count_w), 9);
        btn_down = 1'b1;
        cycles(2);
        rst = 1'b1;
        cycles(1);
        check("mid_rst_count", int'(count_w), 0);
        btn_down = 1'b0;
        cycles(1);
        rst = 1'b0;
        cycles(20);
        check("post_rst_count", int'(count_w), 0);

`ifdef MULTI_BUTTON_COUNTER_AUTOREPEAT_EN
        do_reset();
        btn_up = 1'b1;
        cycles(40);
        btn_up = 1'b0;
        cycles(15);
        check("repeat40_count", int'(count_w), 7);
`endif

        // Randomised button levels with occasional resets.
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            set_btn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
            hold = $urandom_range(1, 12);
            cycles(hold);
        end
        rst = 1'b0;
        set_btn(1'b0, 1'b0, 1'b0);
        cycles(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
